ready_edge_waiter: RTL and testbench



---
 rtl/ready_edge_waiter.sv | 145 ++++++++++++++
 tb/tb_ready_edge_waiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ready_edge_waiter.sv
// Arms on start, waits for a rising edge of ready and reports latency or timeout.
// Build option: define READY_EDGE_WAITER_SYNC_EN to pass ready through a 2-flop synchronizer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; ready rises are only counted
// ST_ARMED | counting cycles until a ready rise or the budget expires
module ready_edge_waiter #(
    parameter int CNT_W  = 8,
    parameter int EDGE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  timeout_cycles,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  latency,
    output logic [EDGE_W-1:0] edge_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);
    localparam logic [EDGE_W-1:0] EDGE_MAX = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   latency_q, latency_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic               done_q, done_d;
    logic               timed_out_q, timed_out_d;
    logic               ready_s;
    logic               ready_q;
    logic               rise;
    logic               expire;

`ifdef READY_EDGE_WAITER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ready;
            sync2_q <= sync1_q;
        end
    end

    assign ready_s = sync2_q;
`else
    assign ready_s = ready;
`endif

    // ready_q resets low, so a level held through reset release reads as one rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_s;
        end
    end

    assign rise   = ready_s & ~ready_q;
    assign expire = (tmo_q != '0) && (cnt_q == (tmo_q - CNT_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            latency_q   <= '0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            edge_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            latency_q   <= latency_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
            edge_q      <= edge_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        latency_d   = latency_q;
        done_d      = 1'b0;
        timed_out_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A rise coinciding with the accepted start is deliberately not a completion.
                if (start) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                    tmo_d   = timeout_cycles;
                end
            end
            ST_ARMED: begin
                if (rise) begin
                    done_d    = 1'b1;
                    latency_d = cnt_q;
                    state_d   = ST_IDLE;
                end else if (expire) begin
                    timed_out_d = 1'b1;
                    latency_d   = tmo_q;
                    state_d     = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        edge_d = edge_q;
        if (rise && (edge_q != EDGE_MAX)) begin
            edge_d = edge_q + EDGE_ONE;
        end
    end

    assign busy       = (state_q == ST_ARMED);
    assign done       = done_q;
    assign timed_out  = timed_out_q;
    assign latency    = latency_q;
    assign edge_count = edge_q;

endmodule

// File: tb/tb_ready_edge_waiter.sv
// Scoreboard bench for ready_edge_waiter: randomized waits checked against a waveform-level model.
module tb_ready_edge_waiter;

    localparam int CNT_W   = 8;
    localparam int EDGE_W  = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;
    localparam int MAXE    = (1 << EDGE_W) - 1;
`ifdef READY_EDGE_WAITER_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  timeout_cycles = '0;
    logic              ready = 1'b0;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  latency;
    logic [EDGE_W-1:0] edge_count;

    ready_edge_waiter #(.CNT_W(CNT_W), .EDGE_W(EDGE_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .timeout_cycles (timeout_cycles),
        .ready          (ready),
        .busy           (busy),
        .done           (done),
        .timed_out      (timed_out),
        .latency        (latency),
        .edge_count     (edge_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     is_done;
        int     lat;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    int     exp_edges = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done || timed_out) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got done=%0d timed_out=%0d expected none (cycle %0d)",
                         done, timed_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {done, timed_out}, e.is_done ? 2 : 1);
                check("latency", latency, e.lat);
                check("pulse_cycle", cyc, e.cyc);
                check("busy_at_pulse", busy, 0);
            end
        end
    end

    // Ready waveform of one transaction, indexed by ARMED cycle (-1 is the start cycle).
    function automatic bit wv(int j, int s1, int h1, int s2, int h2);
        return ((j >= s1) && (j < s1 + h1)) || ((j >= s2) && (j < s2 + h2));
    endfunction

    task automatic run_txn(input int t_budget, input int s1, input int h1, input int gap,
                           input int h2, input bit extra, input bit rel);
        int     s2;
        int     last;
        int     t_rise;
        int     c;
        int     span;
        exp_t   e;
        s2     = s1 + h1 + gap;
        last   = s2 + h2;
        t_rise = -1;
        for (int t = 0; t <= last + D; t++) begin
            if (t_rise < 0 && wv(t - D, s1, h1, s2, h2) && !wv(t - 1 - D, s1, h1, s2, h2))
                t_rise = t;
        end
        if (t_rise >= 0 && (t_budget == 0 || t_rise < t_budget)) begin
            e.is_done = 1'b1;
            e.lat     = (t_rise > MAXC) ? MAXC : t_rise;
            c         = t_rise + 1;
        end else begin
            e.is_done = 1'b0;
            e.lat     = t_budget;
            c         = t_budget;
        end
        exp_edges = (exp_edges + 2 > MAXE) ? MAXE : exp_edges + 2;

        @(posedge clk);
        #1;
        if (rel) rst_n = 1'b1;
        start          = 1'b1;
        timeout_cycles = CNT_W'(t_budget);
        ready          = wv(-1, s1, h1, s2, h2);
        e.cyc          = cyc + 1 + c;
        sb.push_back(e);
        span = (last > c) ? last : c;
        for (int j = 0; j <= span + 1; j++) begin
            @(posedge clk);
            #1;
            start          = extra && (j == 1) && (c >= 2);
            timeout_cycles = CNT_W'($urandom_range(0, MAXC));
            ready          = wv(j, s1, h1, s2, h2);
            if (j == 0) check("busy_armed", busy, 1);
        end
        start = 1'b0;
        ready = 1'b0;
        repeat (4 + $urandom_range(0, 3)) @(posedge clk);
        #1;
        check("edge_count", edge_count, exp_edges);
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_latency", latency, 0);
        check("rst_edge_count", edge_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_txn(20, 5, 3, 4, 2, 1'b0, 1'b0);       // plain completion
        run_txn(10, 15, 2, 2, 2, 1'b0, 1'b0);      // ready stays low through the budget
        run_txn(4, 3 - D, 2, 2, 1, 1'b0, 1'b0);    // rise and expiry on the same edge
        run_txn(20, 2, 1, 1, 1, 1'b1, 1'b0);       // start while ARMED is ignored
        run_txn(8, -1, 2, 2, 2, 1'b0, 1'b0);       // rise alongside the accepted start
        run_txn(0, 260, 2, 2, 1, 1'b0, 1'b0);      // no budget, counter saturates

        // Reset in mid-wait: no pulse, everything cleared.
        @(posedge clk);
        #1;
        start          = 1'b1;
        timeout_cycles = CNT_W'(20);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        ready     = 1'b1;
        exp_edges = 0;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_latency", latency, 0);
        check("midrst_edge_count", edge_count, 0);
        @(negedge clk);
        check("midrst_done", done, 0);
        check("midrst_timed_out", timed_out, 0);
        @(posedge clk);
        run_txn(8, -1, 2, 2, 2, 1'b0, 1'b1);        // released with ready high

        for (int n = 0; n < 40; n++) begin
            int tb_t;
            tb_t = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
            run_txn(tb_t, $urandom_range(0, 26) - 1, $urandom_range(1, 4),
                    $urandom_range(1, 4), $urandom_range(1, 3),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("outstanding_expectations", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
